// File: rtl/tag_ctrl_if.sv
// Request/response and tag-array bus of the two-way tag controller.
// The slave modport is the controller; the master is the core plus tag SRAM.
interface tag_ctrl_if #(
    parameter int unsigned TAG_W = 22,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned OFF_W = 5
);
    logic                         req_valid;
    logic                         req_ready;
    logic [TAG_W+IDX_W+OFF_W-1:0] req_addr;
    logic                         inv_all;
    logic                         resp_valid;
    logic                         resp_hit;
    logic                         resp_way;
    logic                         fill_done;
    logic                         ta_cs;
    logic                         ta_oe;
    logic                         ta_web0;
    logic                         ta_web1;
    logic [IDX_W-1:0]             ta_a;
    logic [TAG_W-1:0]             ta_di;
    logic [TAG_W-1:0]             ta_do0;
    logic [TAG_W-1:0]             ta_do1;

    modport master (
        output req_valid, req_addr, inv_all, fill_done, ta_do0, ta_do1,
        input  req_ready, resp_valid, resp_hit, resp_way,
        input  ta_cs, ta_oe, ta_web0, ta_web1, ta_a, ta_di
    );

    modport slave (
        input  req_valid, req_addr, inv_all, fill_done, ta_do0, ta_do1,
        output req_ready, resp_valid, resp_hit, resp_way,
        output ta_cs, ta_oe, ta_web0, ta_web1, ta_a, ta_di
    );
endinterface

// File: rtl/tag_ctrl.sv
// Two-way set-associative tag controller: lookup against an external tag SRAM,
// LRU victim selection on miss, and tag write-back once the line refill completes.
module tag_ctrl #(
    parameter int unsigned TAG_W = 22,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned OFF_W = 5
) (
    input logic        clk,
    input logic        rstn,
    tag_ctrl_if.slave  bus
);
    localparam int unsigned NSETS = 1 << IDX_W;

    typedef enum logic [1:0] {StIdle, StLookup, StMissWait, StFill} state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic               victim_q;
    logic [NSETS-1:0]   valid0_q, valid1_q, lru_q;

    logic               accept;
    logic               hit0, hit1, hit;
    logic               victim;
    logic               unused_off;

    assign unused_off = ^bus.req_addr[OFF_W-1:0];

    // Gating on rstn keeps the tag array quiet while reset is held.
    assign accept = rstn && (state_q == StIdle) && bus.req_valid && !bus.inv_all;

    assign hit0   = valid0_q[idx_q] && (bus.ta_do0 == tag_q);
    assign hit1   = valid1_q[idx_q] && (bus.ta_do1 == tag_q);
    assign hit    = hit0 || hit1;
    assign victim = !valid0_q[idx_q] ? 1'b0 :
                    !valid1_q[idx_q] ? 1'b1 : lru_q[idx_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept) state_d = StLookup;
            StLookup:   state_d = hit ? StIdle : StMissWait;
            StMissWait: if (bus.fill_done) state_d = StFill;
            StFill:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q    <= '0;
            idx_q    <= '0;
            victim_q <= 1'b0;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (accept) begin
                tag_q <= bus.req_addr[OFF_W+IDX_W +: TAG_W];
                idx_q <= bus.req_addr[OFF_W +: IDX_W];
            end
            if (state_q == StIdle && bus.inv_all) begin
                valid0_q <= '0;
                valid1_q <= '0;
                lru_q    <= '0;
            end else if (state_q == StLookup) begin
                if (hit) begin
                    lru_q[idx_q] <= hit0 ? 1'b1 : 1'b0;
                end else begin
                    victim_q <= victim;
                end
            end else if (state_q == StFill) begin
                if (victim_q) valid1_q[idx_q] <= 1'b1;
                else          valid0_q[idx_q] <= 1'b1;
                lru_q[idx_q] <= ~victim_q;
            end
        end
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_way   = 1'b0;
        bus.ta_cs      = 1'b0;
        bus.ta_oe      = 1'b0;
        bus.ta_web0    = 1'b1;
        bus.ta_web1    = 1'b1;
        bus.ta_a       = '0;
        bus.ta_di      = '0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = rstn && !bus.inv_all;
                if (accept) begin
                    bus.ta_cs = 1'b1;
                    bus.ta_oe = 1'b1;
                    bus.ta_a  = bus.req_addr[OFF_W +: IDX_W];
                end
            end
            StLookup: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit;
                bus.resp_way   = hit ? !hit0 : victim;
            end
            StMissWait: ;
            StFill: begin
                bus.ta_cs   = 1'b1;
                bus.ta_web0 = victim_q;
                bus.ta_web1 = !victim_q;
                bus.ta_a    = idx_q;
                bus.ta_di   = tag_q;
            end
        endcase
    end
endmodule

// File: tb/tb_tag_ctrl.sv
// Bench for tag_ctrl: directed scenarios then random traffic, checked against a
// cache-contents model; a small SRAM model answers the tag array port.
module tb_tag_ctrl;
    logic clk;
    logic rstn;

    tag_ctrl_if bus ();

    tag_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag SRAM: synchronous read, low-active per-way write.
    logic [21:0] mem0 [32];
    logic [21:0] mem1 [32];
    always @(posedge clk) begin
        if (bus.ta_cs && bus.ta_oe) begin
            bus.ta_do0 <= mem0[bus.ta_a];
            bus.ta_do1 <= mem1[bus.ta_a];
        end
        if (bus.ta_cs && !bus.ta_web0) mem0[bus.ta_a] <= bus.ta_di;
        if (bus.ta_cs && !bus.ta_web1) mem1[bus.ta_a] <= bus.ta_di;
    end

    // Reference cache state: what each set holds and which way is least recent.
    logic        m_valid [32][2];
    logic [21:0] m_tag   [32][2];
    logic        m_lru   [32];
    logic [4:0]  p_idx;
    logic [21:0] p_tag;
    logic        p_way;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 32; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s]      = 1'b0;
        end
    endtask

    task automatic lookup(input logic [31:0] addr, output logic hit);
        logic [21:0] t;
        logic [4:0]  s;
        logic        h0, h1, w;
        t  = addr[31:10];
        s  = addr[9:5];
        h0 = m_valid[s][0] && (m_tag[s][0] == t);
        h1 = m_valid[s][1] && (m_tag[s][1] == t);
        hit = h0 || h1;
        if (h0)                  w = 1'b0;
        else if (h1)             w = 1'b1;
        else if (!m_valid[s][0]) w = 1'b0;
        else if (!m_valid[s][1]) w = 1'b1;
        else                     w = m_lru[s];
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        check("req_ready", bus.req_ready, 1);
        check("rd_cs", bus.ta_cs, 1);
        check("rd_oe", bus.ta_oe, 1);
        check("rd_web", {bus.ta_web1, bus.ta_web0}, 2'b11);
        check("rd_a", bus.ta_a, s);
        check("idle_resp", {bus.resp_valid, bus.resp_hit, bus.resp_way}, 3'b000);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        #1;
        check("resp_valid", bus.resp_valid, 1);
        check("resp_hit", bus.resp_hit, hit);
        check("resp_way", bus.resp_way, w);
        check("lk_ready", bus.req_ready, 0);
        if (hit) begin
            m_lru[s] = ~w;
        end else begin
            p_idx = s;
            p_tag = t;
            p_way = w;
        end
    endtask

    task automatic miss_wait(input int n, input logic poke);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req_valid = poke;
            bus.inv_all   = poke;
            #1;
            check("mw_ready", bus.req_ready, 0);
            check("mw_cs", bus.ta_cs, 0);
            check("mw_idle", {bus.ta_a, bus.ta_di, bus.ta_web1, bus.ta_web0}, 29'h3);
            check("mw_resp", {bus.resp_valid, bus.resp_hit, bus.resp_way}, 3'b000);
        end
        bus.req_valid = 1'b0;
        bus.inv_all   = 1'b0;
    endtask

    task automatic fill();
        @(negedge clk);
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_done = 1'b0;
        #1;
        check("fill_cs", bus.ta_cs, 1);
        check("fill_oe", bus.ta_oe, 0);
        check("fill_web0", bus.ta_web0, p_way);
        check("fill_web1", bus.ta_web1, !p_way);
        check("fill_a", bus.ta_a, p_idx);
        check("fill_di", bus.ta_di, p_tag);
        m_valid[p_idx][p_way] = 1'b1;
        m_tag[p_idx][p_way]   = p_tag;
        m_lru[p_idx]          = ~p_way;
        @(negedge clk);
        #1;
        check("post_fill_ready", bus.req_ready, 1);
    endtask

    task automatic inv();
        @(negedge clk);
        bus.inv_all   = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = $urandom;
        #1;
        check("inv_ready", bus.req_ready, 0);
        check("inv_cs", bus.ta_cs, 0);
        @(negedge clk);
        bus.inv_all   = 1'b0;
        bus.req_valid = 1'b0;
        model_clear();
    endtask

    logic        h;
    logic [21:0] pool [3];
    logic [4:0]  sets [4];
    logic [21:0] keep0, keep1;

    initial begin
        for (int s = 0; s < 32; s++) begin
            mem0[s]     = '0;
            mem1[s]     = '0;
            m_tag[s][0] = '0;
            m_tag[s][1] = '0;
        end
        model_clear();
        rstn          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1020;
        bus.inv_all   = 1'b0;
        bus.fill_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_cs", bus.ta_cs, 0);
        check("rst_web", {bus.ta_web1, bus.ta_web0}, 2'b11);
        bus.req_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check("rel_ready", bus.req_ready, 1);

        // First fill of set 1, then a hit, then the second way.
        lookup(32'h0000_1020, h);
        check("d1_miss", h, 0);
        miss_wait(2, 1'b0);
        fill();
        check("d1_mem", mem0[1], 22'h4);
        lookup(32'h0000_1020, h);
        check("d2_hit", h, 1);
        lookup(32'h0000_2020, h);
        check("d3_victim", p_way, 1);
        miss_wait(1, 1'b0);
        fill();
        lookup(32'h0000_1020, h);
        lookup(32'h0000_2020, h);
        lookup(32'h0000_3020, h);
        check("d4_lru_victim", p_way, 0);
        // inv_all while waiting for the refill must be ignored.
        miss_wait(2, 1'b1);
        fill();
        lookup(32'h0000_3020, h);
        check("d4_hit", h, 1);

        inv();
        lookup(32'h0000_1020, h);
        check("d5_miss_after_inv", h, 0);
        miss_wait(1, 1'b0);
        fill();

        // Reset while waiting for a refill: nothing may be written.
        lookup(32'h0000_2020, h);
        keep0 = mem0[1];
        keep1 = mem1[1];
        miss_wait(1, 1'b0);
        @(negedge clk);
        rstn          = 1'b0;
        bus.fill_done = 1'b1;
        #1;
        check("ra_resp_valid", bus.resp_valid, 0);
        check("ra_cs", bus.ta_cs, 0);
        check("ra_web", {bus.ta_web1, bus.ta_web0}, 2'b11);
        @(negedge clk);
        bus.fill_done = 1'b0;
        rstn = 1'b1;
        model_clear();
        #1;
        check("ra_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.fill_done = 1'b1;
        #1;
        check("ra_fd_cs", bus.ta_cs, 0);
        @(negedge clk);
        bus.fill_done = 1'b0;
        #1;
        check("ra_fd_cs2", bus.ta_cs, 0);
        check("ra_fd_ready", bus.req_ready, 1);
        check("ra_mem0", mem0[1], keep0);
        check("ra_mem1", mem1[1], keep1);
        lookup(32'h0000_1020, h);
        check("ra_miss", h, 0);
        miss_wait(1, 1'b0);
        fill();

        // Random traffic over three tags sharing four sets to exercise eviction.
        for (int i = 0; i < 3; i++) pool[i] = 22'($urandom);
        sets[0] = 5'd0;
        sets[1] = 5'd1;
        sets[2] = 5'd2;
        sets[3] = 5'd31;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                inv();
            end else begin
                lookup({pool[$urandom_range(0, 2)], sets[$urandom_range(0, 3)],
                        5'($urandom)}, h);
                if (!h) begin
                    miss_wait($urandom_range(0, 3), 1'($urandom));
                    fill();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tag_ctrl.md
TAG_CTRL -- requirements
Module: tag_ctrl

Interface
REQ-001 Parameters SHALL be: TAG_W, 22, tag width; IDX_W, 5, set index width (32 sets); OFF_W, 5, line offset width (32-byte line); TAG_W+IDX_W+OFF_W SHALL equal 32.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock, all state on rising edge.
- rstn in 1: asynchronous active-low reset.
- req_valid in 1: lookup request.
- req_ready out 1: request accepted when req_valid&&req_ready.
- req_addr in 32: byte address; tag=[31:10], idx=[9:5].
- inv_all in 1: invalidate all sets.
- resp_valid out 1: lookup result valid (1-cycle pulse).
- resp_hit out 1: 1=hit, 0=miss.
- resp_way out 1: hit way, or victim way on miss.
- fill_done in 1: line refill finished (1-cycle pulse).
- ta_cs out 1: tag array chip select, active high.
- ta_oe out 1: tag array output enable.
- ta_web0 out 1: way-0 write enable, active low.
- ta_web1 out 1: way-1 write enable, active low.
- ta_a out 5: tag array set address.
- ta_di out 22: tag write data.
- ta_do0 in 22: way-0 read data, valid 1 cycle after read.
- ta_do1 in 22: way-1 read data, valid 1 cycle after read.

Function
REQ-003 The block SHALL hold valid[32][2] and lru[32] in flops; lru[i] names the least-recently-used way of set i.
REQ-004 FSM states SHALL be IDLE, LOOKUP, MISS_WAIT, FILL, with transitions only as in REQ-005..REQ-010.
REQ-005 IDLE: req_ready=1 unless inv_all=1; on accept, latch tag/idx, drive ta_cs=1, ta_oe=1, ta_web0=ta_web1=1, ta_a=req_addr[9:5], go to LOOKUP.
REQ-006 LOOKUP: hitN = valid[idx][N] && (ta_doN==latched tag); assert resp_valid=1 for exactly this cycle.
REQ-007 LOOKUP hit: resp_hit=1; resp_way = 0 if hit0, else 1 (way 0 wins if both hit); lru[idx] <= ~resp_way; go to IDLE.
REQ-008 LOOKUP miss: resp_hit=0; victim = 0 if !valid[idx][0], else 1 if !valid[idx][1], else lru[idx]; resp_way=victim; latch victim; go to MISS_WAIT.
REQ-009 MISS_WAIT: req_ready=0, tag array idle (ta_cs=0); stay until fill_done=1, then go to FILL. fill_done in any other state SHALL be ignored.
REQ-010 FILL (1 cycle): ta_cs=1, ta_oe=0, ta_web<victim>=0, other web=1, ta_a=idx, ta_di=tag; valid[idx][victim] <= 1; lru[idx] <= ~victim; go to IDLE.
REQ-011 inv_all=1 in IDLE SHALL clear all valid and lru bits in that cycle with no request accepted; inv_all in other states SHALL be ignored.
REQ-012 Lookup latency SHALL be exactly 1 cycle from accept to resp_valid; back-to-back hits SHALL sustain one request per 2 cycles.
REQ-013 When not specified above, ta_cs=0, ta_oe=0, ta_web0=ta_web1=1, ta_a=0, ta_di=0.
REQ-014 resp_hit and resp_way SHALL be 0 whenever resp_valid=0.

Reset
REQ-015 rstn=0 SHALL immediately force state=IDLE, all valid=0, all lru=0, resp_valid=0, ta_cs=0, ta_web0=ta_web1=1; req_ready=1 from the first clock after rstn deassertion.
REQ-016 Reset asserted in MISS_WAIT or FILL SHALL abort the fill with no tag write committed on reset cycles.

Verification
REQ-017 After reset, request 0x0000_1020 (idx 1) -> ta_a=1 read, then resp_valid=1, resp_hit=0, resp_way=0; fill_done -> FILL writes ta_di=0x4 into way 0 of set 1 with ta_web0=0.
REQ-018 Repeat 0x0000_1020 -> resp_hit=1, resp_way=0, lru[1]=1.
REQ-019 Request 0x0000_2020 (same set, new tag) -> miss, victim way 1; after fill, 0x0000_1020 hits way 0 and 0x0000_2020 hits way 1.
REQ-020 Both ways valid, set 1 last touched way 1, request 0x0000_3020 -> miss with resp_way=0 (LRU victim).
REQ-021 inv_all and req_valid both high in IDLE -> req_ready=0, all valid cleared; next lookup of 0x0000_1020 misses.
REQ-022 rstn pulsed low in MISS_WAIT, then fill_done -> no tag write, state IDLE, req_ready=1, all lookups miss.
